// File: rtl/bus8088_pkg.sv
// Shared types and defaults for the 8088 local-bus arbitration blocks.
package bus8088_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_REQ,
        GRANT,
        RELEASE,
        WAIT_HLDA_LO
    } arb_state_t;

    localparam int unsigned DEF_NREQ       = 2;
    localparam int unsigned DEF_MAX_TENURE = 64;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_hold_arbiter_if.sv
// Requester/CPU-side signal bundle of bus_hold_arbiter; master is the arbiter side.
interface bus_hold_arbiter_if
    import bus8088_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) ();

    localparam int unsigned IW = idx_width(NREQ);

    logic [NREQ-1:0] req;
    logic            hlda;
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic            busen;
    logic [IW-1:0]   owner;
    logic            preempt;

    modport master (
        input  req,
        input  hlda,
        output hold,
        output gnt,
        output busen,
        output owner,
        output preempt
    );

    modport slave (
        output req,
        output hlda,
        input  hold,
        input  gnt,
        input  busen,
        input  owner,
        input  preempt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import bus8088_pkg::*;
#(
    parameter int unsigned N  = DEF_NREQ,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] rot;
    int unsigned  j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        rot    = '0;
        j      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j   = (32'(ptr) + i) % N;
            rot = req >> j;
            if (!valid && rot[0]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
        if (valid) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the 8088 local bus between the CPU (via HOLD/HLDA) and NREQ round-robin requesters.
// Define ARB_TENURE_LIMIT_EN to cap each grant at MAX_TENURE cycles with a PREEMPT pulse.
module bus_hold_arbiter
    import bus8088_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned MAX_TENURE = DEF_MAX_TENURE,
    parameter int unsigned CNT_W      = $clog2(MAX_TENURE + 1)
) (
    input logic                clk,
    input logic                rst,
    bus_hold_arbiter_if.master bus
);

    localparam int unsigned IW = idx_width(NREQ);

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("bus_hold_arbiter: NREQ must be 1..8");
    end
    if (MAX_TENURE < 1 || CNT_W < $clog2(MAX_TENURE + 1)) begin : g_bad_tenure
        $error("bus_hold_arbiter: MAX_TENURE/CNT_W inconsistent");
    end

    arb_state_t      state_q, state_d;
    logic            hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d, ptr_next;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] req_sh;
    logic            owner_req;
    logic            limit_hit;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign req_sh    = bus.req >> owner_q;
    assign owner_req = req_sh[0];
    // Last grantee goes to the back of the queue.
    assign ptr_next  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef ARB_TENURE_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    assign limit_hit = (cnt_q == CNT_W'(MAX_TENURE - 1));

    always_comb begin
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        if (state_q == HOLD_REQ) begin
            cnt_d = '0;
        end else if (state_q == GRANT) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            preempt_d = bus.hlda && owner_req && limit_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.preempt = preempt_q;
`else
    assign limit_hit   = 1'b0;
    assign bus.preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = HOLD_REQ;
                    hold_d  = 1'b1;
                end
            end
            HOLD_REQ: begin
                // The CPU cycle in flight is never aborted: wait for HLDA even if REQ vanished.
                if (bus.hlda) begin
                    if (pick_valid) begin
                        state_d = GRANT;
                        gnt_d   = pick_onehot;
                        owner_d = pick_idx;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            GRANT: begin
                if (!bus.hlda) begin
                    state_d = WAIT_HLDA_LO;
                    hold_d  = 1'b0;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end else if (!owner_req || limit_hit) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end
            end
            RELEASE: begin
                state_d = WAIT_HLDA_LO;
                hold_d  = 1'b0;
            end
            WAIT_HLDA_LO: begin
                if (!bus.hlda) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.hold  = hold_q;
    assign bus.gnt   = gnt_q;
    assign bus.busen = |gnt_q;
    assign bus.owner = owner_q;

endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
- Shares the 8088 local bus (AD/A, IOM, RD, WR, ALE, DTR, DEN) between the CPU and NREQ secondary bus masters (DMA engines, test masters).
- Drives the CPU HOLD input, watches HLDA, and gives one requester at a time a one-hot grant with round-robin fairness.
- Controls the turnaround so no two masters drive the bus in the same cycle.
- Sits in top between the requesters and the Intel8088 HOLD/HLDA pins. Its BUSEN output gates the requester-side 8282/8286 enables.

Parameters:
- NREQ, 2, number of secondary requesters (1..8)
- MAX_TENURE, 64, maximum CLK cycles one grant may last; used only with ARB_TENURE_LIMIT_EN
- CNT_W, $clog2(MAX_TENURE+1), width of the tenure counter

Ports:
- CLK  in  1  system clock; all state changes on posedge
- RESET  in  1  asynchronous, active-high reset
- REQ  in  NREQ  bus request per requester; synchronous to CLK; level held while the requester wants the bus
- HLDA  in  1  hold acknowledge from the 8088
- HOLD  out  1  hold request to the 8088
- GNT  out  NREQ  one-hot grant; at most one bit set
- BUSEN  out  1  requester-side bus drivers enabled; high only in GRANT
- OWNER  out  $clog2(NREQ) (min 1)  index of the current or last grantee
- PREEMPT  out  1  one-cycle pulse when a tenure is cut by the limit

Behaviour:
- Reset (async): state=IDLE; HOLD=0, GNT=0, BUSEN=0, OWNER=0, PREEMPT=0; round-robin pointer=0; tenure counter=0.
- State machine:
  - IDLE: if |REQ, go to HOLD_REQ with HOLD=1 on the next edge; else stay.
  - HOLD_REQ: hold HOLD=1. When HLDA=1 is sampled, pick the winner: first set bit of REQ at or after the pointer, wrapping modulo NREQ. Next edge: GNT[winner]=1, BUSEN=1, OWNER=winner, counter cleared, state=GRANT.
  - HOLD_REQ, all REQ dropped before HLDA: stay until HLDA=1, then go to RELEASE with no grant. The CPU cycle is never aborted.
  - GRANT: counter increments each cycle, saturating. Leave when REQ[OWNER]=0 or when the tenure limit fires. Next edge: GNT=0, BUSEN=0, state=RELEASE. The pointer becomes (OWNER+1) mod NREQ.
  - RELEASE: exactly one turnaround cycle with HOLD still 1 and no driver enabled. Then HOLD=0 and state=WAIT_HLDA_LO.
  - WAIT_HLDA_LO: stay while HLDA=1. When HLDA=0, return to IDLE.
  - A pending REQ is re-arbitrated through IDLE→HOLD_REQ. HOLD is never reasserted before HLDA drops, which gives the CPU at least one bus cycle between grants.
- Latency: REQ rise → HOLD one cycle later; HLDA sampled → GNT one cycle later; REQ fall → GNT/BUSEN low one cycle later → HOLD low two cycles later.
- Grant stability:
  - GNT never changes during GRANT.
  - New REQ bits during GRANT are ignored until the next arbitration.
  - GNT and BUSEN are always equal-valued: BUSEN = |GNT.
- HLDA dropping unexpectedly in GRANT (protocol error): GNT/BUSEN drop on the next edge, state goes to WAIT_HLDA_LO, HOLD=0.
- RESET mid-tenure: all outputs go low immediately (async). The requester must tolerate losing GNT.
- NREQ=1: the pointer is a constant 0; fairness logic is degenerate but legal.

Optional Feature:
- Macro: ARB_TENURE_LIMIT_EN.
- Defined:
  - When the counter reaches MAX_TENURE-1 in GRANT while REQ[OWNER]=1, exit to RELEASE.
  - PREEMPT pulses high for 1 cycle on the edge GNT drops.
  - The pointer advances, so the preempted requester goes last.
- Undefined:
  - The counter and PREEMPT logic are removed and PREEMPT is tied to 0.
  - A tenure ends only when REQ[OWNER] falls.

Decomposition:
- Package bus8088_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, HOLD_REQ, GRANT, RELEASE, WAIT_HLDA_LO}
  - localparam DEF_NREQ=2, DEF_MAX_TENURE=64
- Sub-module rr_pick: combinational round-robin finder (req vector + pointer → one-hot plus index, valid flag). It is reused by later interrupt and DMA-channel schedulers.

Test Plan:
- Single request: after reset, REQ=2'b01 at cycle 10, HLDA returned 3 cycles after HOLD → HOLD=1 at cycle 11, GNT=01 and BUSEN=1 one cycle after HLDA sampled. REQ dropped → GNT=0 next cycle, HOLD=0 one cycle later.
- Round-robin: REQ=2'b11 held continuously → grants alternate 01,10,01,10 across 4 tenures. HOLD is low for at least one cycle between tenures, and GNT is never 11.
- Withdrawn request: REQ=01 pulsed for 1 cycle, HLDA arrives 4 cycles later → no GNT ever asserts; HOLD falls 2 cycles after HLDA.
- Tenure limit (with ARB_TENURE_LIMIT_EN, MAX_TENURE=8): REQ=01 held forever → GNT high exactly 8 cycles, PREEMPT pulses once, regrant after HLDA cycles low. Without the macro, GNT stays high for 200 cycles.
- Async reset mid-GRANT: assert RESET between clock edges → HOLD, GNT, BUSEN and PREEMPT all 0 before the next posedge; after release, REQ=10 is granted first (pointer=0, bit 0 not requesting).
- Protocol error: force HLDA=0 while GNT=10 → GNT/BUSEN drop next edge, HOLD=0, state returns to IDLE once HLDA is low.
